// File: rtl/apb_buffer_slave.sv
// apb_buffer_slave: APB completer that pushes write data into a FIFO and reports write-data parity
module apb_buffer_slave #(
  parameter int m           = 8,
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [m-1:0]             PWDATA,
  output logic                     PREADY,
  output logic                     PRDATA,
  output logic [m-1:0]             o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic                     i_rd_pop
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t          r_state, w_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic            r_pready, r_prdata;
  logic [m-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
  logic [AW:0]     r_count, w_count_next;
  logic [m-1:0]    r_rd_data, w_head_next;
  logic            w_push, w_pop;
  assign w_push       = (r_state == S_DONE) && PWRITE;
  assign w_pop        = i_rd_pop && !o_empty;
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
  assign o_empty      = r_count == '0;
  assign o_full       = r_count == (AW+1)'(DEPTH);
  assign o_count      = r_count;
  assign o_rd_data    = r_rd_data;
  assign PREADY       = r_pready;
  assign PRDATA       = r_prdata;
  // Transfer sequencing: setup -> wait states (plus stalls while full) -> one-cycle completion
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (r_state == S_IDLE) begin
      if (PSEL && !PENABLE) begin
        w_next     = S_WAIT;
        w_cnt_next = 4'(WAIT_CYCLES);
      end
    end else if (r_state == S_WAIT) begin
      if (!PSEL) w_next = S_IDLE;
      else if (r_cnt != 4'd0) w_cnt_next = r_cnt - 4'd1;
      else if (!PWRITE || !o_full) w_next = S_DONE;
    end else begin
      w_next = S_IDLE;
    end
  end
  // State, wait counter and registered PREADY (high exactly while in DONE)
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_pready <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_pready <= w_next == S_DONE;
    end
  end
  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= PWDATA;
  end
  // Next occupancy and next head value; a pop of the last entry with a push bypasses PWDATA
  always_comb begin
    w_count_next = (w_push && !w_pop) ? r_count + 1'b1 :
                   (w_pop && !w_push) ? r_count - 1'b1 : r_count;
    w_head_next  = w_pop ? ((r_count != (AW+1)'(1)) ? r_mem[w_rd_ptr_inc] :
                            (w_push ? PWDATA : r_rd_data)) :
                   ((w_push && o_empty) ? PWDATA : r_rd_data);
  end
  // Pointers, occupancy, registered head and parity status
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_prdata  <= 1'b0;
    end else begin
      r_wr_ptr  <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr  <= w_pop ? w_rd_ptr_inc : r_rd_ptr;
      r_count   <= w_count_next;
      r_rd_data <= w_head_next;
      r_prdata  <= w_push ? ^PWDATA : r_prdata;
    end
  end
endmodule

// File: tb/tb_apb_buffer_slave.sv
// tb_apb_buffer_slave: directed APB transfers checked against a transaction-level FIFO/timing model
module tb_apb_buffer_slave;
  localparam int DEPTH = 4;
  localparam int WC    = 1;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pop = 1'b0;
  logic [7:0] pwdata = 8'h00;
  logic       pready, prdata, empty, full;
  logic [7:0] rd_data;
  logic [2:0] count;
  int         n_chk = 0, n_fail = 0;

  apb_buffer_slave #(.m(8), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .PCLK(clk), .PRESET(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PWDATA(pwdata), .PREADY(pready), .PRDATA(prdata), .o_rd_data(rd_data),
    .o_empty(empty), .o_full(full), .o_count(count), .i_rd_pop(pop));

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue; a transfer that set up at edge s completes (PREADY high)
  // after the first edge >= s+WC+1 at which it is a read or the queue is not full,
  // unless PSEL was dropped first.
  logic [7:0] q[$];
  int  edge_n = 0, start_n = 0, oc;
  bit  active = 0, e_ready = 0, e_prdata = 0, do_pop, do_push;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      active = 0;
      e_ready = 0;
      e_prdata = 0;
    end else begin
      edge_n++;
      oc      = q.size();
      do_pop  = pop && oc > 0;
      do_push = e_ready && pwrite;
      if (e_ready) begin
        if (pwrite) e_prdata = ^pwdata;
        e_ready = 0;
      end else if (active) begin
        if (!psel) active = 0;
        else if (edge_n - start_n >= WC + 1 && (!pwrite || oc < DEPTH)) begin
          e_ready = 1;
          active  = 0;
        end
      end else if (psel && !penable) begin
        active  = 1;
        start_n = edge_n;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(pwdata);
    end
  end

  // Every falling edge: all outputs against the model
  initial forever begin
    @(negedge clk);
    chk("m_pready", 32'(pready), 32'(e_ready));
    chk("m_prdata", 32'(prdata), 32'(e_prdata));
    chk("m_count", 32'(count), q.size());
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == DEPTH));
    if (q.size() > 0) chk("m_head", 32'(rd_data), 32'(q[0]));
  end

  task automatic xfer(input logic wr, input logic [7:0] d, input int budget, output int rc);
    int k;
    psel = 1'b1; penable = 1'b0; pwrite = wr; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    k = 1;
    while (!pready && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    rc = pready ? k : 0;
    if (pready) begin
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
  endtask

  logic [8:0] ops [12];
  int rc;
  initial begin
    ops[0] = 9'h0AA; ops[1] = 9'h0AB; ops[2] = 9'h0AC; ops[3] = 9'h1AA;
    ops[4] = 9'h0AD; ops[5] = 9'h0AE; ops[6] = 9'h1AB; ops[7] = 9'h1AC;
    ops[8] = 9'h0AF; ops[9] = 9'h1AD; ops[10] = 9'h1AE; ops[11] = 9'h1AF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", 32'(pready), 0);
    chk("rst_prdata", 32'(prdata), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 8'hC8, 20, rc);
    chk("t2_latency", rc, 3);
    chk("t2_pready_low", 32'(pready), 0);
    chk("t2_count", 32'(count), 1);
    chk("t2_rd_data", 32'(rd_data), 32'h C8);
    chk("t2_prdata", 32'(prdata), 1);
    pop_one();
    chk("t3_empty", 32'(empty), 1);
    for (int i = 1; i <= 4; i++) begin
      xfer(1'b1, 8'(i), 20, rc);
      chk("t3_latency", rc, 3);
    end
    chk("t3_full", 32'(full), 1);
    fork
      xfer(1'b1, 8'h05, 30, rc);
      begin
        repeat (4) @(posedge clk);
        #1;
        pop = 1'b1;
        @(posedge clk); #1;
        chk("t3_head_after_pop", 32'(rd_data), 2);
        chk("t3_count_after_pop", 32'(count), 3);
        pop = 1'b0;
      end
    join
    chk("t3_stall_ready", rc, 6);
    chk("t3_count", 32'(count), 4);
    chk("t3_full_again", 32'(full), 1);
    for (int i = 2; i <= 5; i++) begin
      chk("t4_drain", 32'(rd_data), i);
      pop_one();
    end
    chk("t4_empty", 32'(empty), 1);
    xfer(1'b1, 8'hC9, 20, rc);
    chk("t4_wr_latency", rc, 3);
    chk("t4_prdata_wr", 32'(prdata), 0);
    xfer(1'b0, 8'h01, 20, rc);
    chk("t4_rd_latency", rc, 3);
    chk("t4_prdata_rd", 32'(prdata), 0);
    chk("t4_count", 32'(count), 1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t5_no_ready", 32'(pready), 0);
    end
    chk("t5_count", 32'(count), 1);
    pop_one();
    for (int i = 0; i < 12; i++) begin
      if (ops[i][8]) begin
        chk("t6_pop_order", 32'(rd_data), 32'(ops[i][7:0]));
        pop_one();
      end else begin
        xfer(1'b1, ops[i][7:0], 20, rc);
        chk("t6_latency", rc, 3);
      end
    end
    chk("t6_empty", 32'(empty), 1);
    xfer(1'b1, 8'h5A, 20, rc);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'hBB;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_pready", 32'(pready), 0);
    chk("rst_wait_empty", 32'(empty), 1);
    chk("rst_wait_count", 32'(count), 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = 8'h3C;
    repeat (3) begin
      @(posedge clk); #1;
      penable = 1'b1;
    end
    chk("rst_done_pre", 32'(pready), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_pready", 32'(pready), 0);
    chk("rst_done_count", 32'(count), 0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1'b1, 8'h3C, 20, rc);
    chk("recover_latency", rc, 3);
    chk("recover_count", 32'(count), 1);
    chk("recover_prdata", 32'(prdata), 0);
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
